mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one 32-bit word store among NCH requesters (word/half/byte access).
// Ready/err pulse LATENCY+1 cycles after the grant edge; a requester holds req and its command until its ready.
module mem_arbiter #(
  parameter int    NCH       = 2,
  parameter int    DEPTH     = 1024,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    req,
  input  logic [NCH-1:0]    we,
  input  logic [2*NCH-1:0]  mode,
  input  logic [32*NCH-1:0] addr,
  input  logic [32*NCH-1:0] wdata,
  output logic [32*NCH-1:0] rdata,
  output logic [NCH-1:0]    ready,
  output logic [NCH-1:0]    err,
  output logic              busy
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [CW-1:0]       r_ptr, r_gnt, w_gnt, w_ptr_nxt;
  logic                w_found;
  logic                r_we;
  logic [1:0]          r_mode;
  logic [31:0]         r_addr, r_wdata;
  logic [3:0]          r_cnt;
  logic [NCH-1:0]      r_ready, r_err;
  logic [32*NCH-1:0]   r_rdata;
  logic [31:0]         r_mem [DEPTH];

  logic [AW-1:0]       w_widx;
  logic                w_fault, w_last, w_commit;
  logic [31:0]         w_word, w_rd, w_wword;

  // First requester at or after r_ptr, wrapping; r_ptr holds the channel after the last grant.
  always_comb begin
    w_gnt   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (!w_found && req[(int'(r_ptr) + i) % NCH]) begin
        w_gnt   = CW'((int'(r_ptr) + i) % NCH);
        w_found = 1'b1;
      end
    end
    w_ptr_nxt = CW'((int'(w_gnt) + 1) % NCH);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_WAIT;
      S_WAIT:  if (r_cnt == 4'd0) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  assign w_widx  = r_addr[AW+1:2];
  assign w_word  = r_mem[w_widx];
  assign w_last  = (r_state == S_WAIT) && (r_cnt == 4'd0);
  assign w_fault = (r_addr[31:2] >= 30'(DEPTH))
                 | (((r_mode == 2'b00) || (r_mode == 2'b11)) && (r_addr[1:0] != 2'b00))
                 | ((r_mode == 2'b01) && r_addr[0]);
  assign w_commit = w_last && r_we && !w_fault && !reset;

  always_comb begin
    case (r_mode)
      2'b01:   w_rd = {16'h0000, w_word[{r_addr[1], 4'b0000} +: 16]};
      2'b10:   w_rd = {24'h000000, w_word[{r_addr[1:0], 3'b000} +: 8]};
      default: w_rd = w_word;
    endcase
  end

  // Merge only the addressed byte lanes of the write into the current word.
  always_comb begin
    w_wword = w_word;
    for (int b = 0; b < 4; b++) begin
      case (r_mode)
        2'b10:   if (r_addr[1:0] == 2'(b)) w_wword[8*b +: 8] = r_wdata[7:0];
        2'b01:   if (r_addr[1] == 1'(b / 2)) w_wword[8*b +: 8] = r_wdata[8*(b % 2) +: 8];
        default: w_wword[8*b +: 8] = r_wdata[8*b +: 8];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit) r_mem[w_widx] <= w_wword;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_we    <= 1'b0;
      r_mode  <= 2'b00;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_ready <= '0;
      r_err   <= '0;
      r_rdata <= '0;
    end else begin
      r_ready <= '0;
      r_err   <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt   <= w_gnt;
            r_ptr   <= w_ptr_nxt;
            r_we    <= we[w_gnt];
            r_mode  <= mode[2*w_gnt +: 2];
            r_addr  <= addr[32*w_gnt +: 32];
            r_wdata <= wdata[32*w_gnt +: 32];
            r_cnt   <= 4'(LATENCY - 1);
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_ready[r_gnt] <= 1'b1;
            r_err[r_gnt]   <= w_fault;
            if (w_fault)    r_rdata[32*r_gnt +: 32] <= '0;
            else if (!r_we) r_rdata[32*r_gnt +: 32] <= w_rd;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready = r_ready;
  assign err   = r_err;
  assign rdata = r_rdata;
  assign busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, checked against a byte-array store model
// and a round-robin grant model.
module tb_mem_arbiter;
  localparam int NCH   = 4;
  localparam int DEPTH = 16;
  localparam int LAT   = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NCH-1:0]    req, we, ready, err, keep;
  logic [2*NCH-1:0]  mode;
  logic [32*NCH-1:0] addr, wdata, rdata;
  logic              busy;

  int          nvec = 0;
  int          nerr = 0;
  int          ptr  = 0;
  logic [7:0]  mb  [4*DEPTH];
  logic [31:0] mrd [NCH];

  mem_arbiter #(.NCH(NCH), .DEPTH(DEPTH), .LATENCY(LAT), .INIT_FILE("")) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .mode(mode), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ready(ready), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input int c, input logic w, input logic [1:0] m,
                         input logic [31:0] a, input logic [31:0] d);
    we[c] = w;
    mode[2*c +: 2] = m;
    addr[32*c +: 32] = a;
    wdata[32*c +: 32] = d;
  endtask

  task automatic rand_cmd(input int c);
    logic [1:0]  m;
    logic [31:0] a;
    m = 2'($urandom_range(0, 3));
    a = $urandom_range(0, 4*DEPTH + 7);
    if ($urandom_range(0, 3) != 0)
      a = a & ((m == 2'b01) ? ~32'd1 : (m == 2'b10) ? ~32'd0 : ~32'd3);
    set_cmd(c, 1'($urandom_range(0, 1)), m, a, $urandom);
  endtask

  // Store model: byte-addressed array, sizes in bytes, little-endian.
  task automatic model_access(input int c, output logic e);
    logic [31:0] a, v;
    logic [1:0]  m;
    int          n;
    a = addr[32*c +: 32];
    m = mode[2*c +: 2];
    n = (m == 2'b01) ? 2 : (m == 2'b10) ? 1 : 4;
    e = ((a % n) != 0) || ((a / 4) >= DEPTH);
    if (e) mrd[c] = 32'h0;
    else if (we[c]) begin
      for (int k = 0; k < n; k++) mb[a + k] = wdata[32*c + 8*k +: 8];
    end else begin
      v = 32'h0;
      for (int k = 0; k < n; k++) v[8*k +: 8] = mb[a + k];
      mrd[c] = v;
    end
  endtask

  task automatic do_reset(input logic [NCH-1:0] mask);
    reset = 1'b1;
    req = mask;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    for (int c = 0; c < NCH; c++) check($sformatf("rst_rdata%0d", c), rdata[32*c +: 32], 32'h0);
    reset = 1'b0;
    ptr = 0;
    for (int c = 0; c < NCH; c++) mrd[c] = 32'h0;
  endtask

  // Starts at a negedge in IDLE with req set; ends at the negedge of the following IDLE cycle.
  task automatic do_round(output int g);
    int   lat;
    logic e;
    g = -1;
    for (int i = 0; i < NCH; i++) if (g < 0 && req[(ptr + i) % NCH]) g = (ptr + i) % NCH;
    if (g < 0) g = 0;
    model_access(g, e);
    ptr = (g + 1) % NCH;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (ready == '0 && lat <= LAT) check("busy_wait", 32'(busy), 32'h1);
    end while (ready == '0 && lat < LAT + 6);
    check("latency", lat, LAT + 1);
    check("ready", 32'(ready), 32'(1 << g));
    check("err", 32'(err), e ? 32'(1 << g) : 32'h0);
    check("busy_done", 32'(busy), 32'h1);
    for (int c = 0; c < NCH; c++) check($sformatf("rdata%0d", c), rdata[32*c +: 32], mrd[c]);
    if (!keep[g]) req[g] = 1'b0;
    @(negedge clk);
    check("ready_clear", 32'(ready), 32'h0);
    check("busy_idle", 32'(busy), 32'h0);
  endtask

  initial begin
    int g;
    reset = 1'b1; req = '0; we = '0; mode = '0; addr = '0; wdata = '0; keep = '0;
    do_reset('0);

    for (int w = 0; w < DEPTH; w++) begin
      set_cmd(w % NCH, 1'b1, 2'b00, 32'(4 * w), $urandom);
      req = NCH'(1) << (w % NCH);
      do_round(g);
    end

    set_cmd(1, 1'b1, 2'b00, 32'h0, 32'h8C010004); req = 4'b0010; do_round(g);
    set_cmd(0, 1'b0, 2'b00, 32'h0, 32'h0);        req = 4'b0001; do_round(g);
    check("single_read", rdata[31:0], 32'h8C010004);

    set_cmd(0, 1'b1, 2'b00, 32'h4, 32'h11223344); req = 4'b0001; do_round(g);
    set_cmd(1, 1'b1, 2'b10, 32'h5, 32'h000000AB); req = 4'b0010; do_round(g);
    set_cmd(0, 1'b0, 2'b00, 32'h4, 32'h0);        req = 4'b0001; do_round(g);
    check("byte_merge", rdata[31:0], 32'h1122AB44);
    set_cmd(1, 1'b0, 2'b01, 32'h6, 32'h0);        req = 4'b0010; do_round(g);
    check("half_read", rdata[63:32], 32'h00001122);

    set_cmd(0, 1'b0, 2'b00, 32'h8, 32'h0);
    set_cmd(1, 1'b0, 2'b00, 32'hC, 32'h0);
    keep = 4'b0011;
    do_reset(4'b0011);
    for (int r = 0; r < 4; r++) begin
      do_round(g);
      check("contention_grant", g, r % 2);
    end
    keep = '0; req = '0;

    set_cmd(0, 1'b0, 2'b00, 32'h2, 32'h0); req = 4'b0001; do_round(g);
    check("fault_rd_rdata", rdata[31:0], 32'h0);
    set_cmd(1, 1'b1, 2'b00, 32'(4 * DEPTH), 32'hFFFFFFFF); req = 4'b0010; do_round(g);
    set_cmd(0, 1'b0, 2'b00, 32'h0, 32'h0); req = 4'b0001; do_round(g);
    check("fault_wr_kept", rdata[31:0], 32'h8C010004);

    set_cmd(1, 1'b1, 2'b00, 32'h10, 32'hDEADBEEF); req = 4'b0010;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy_wait", 32'(busy), 32'h1);
    reset = 1'b1; req = '0;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_ready", 32'(ready), 32'h0);
    reset = 1'b0; ptr = 0;
    for (int c = 0; c < NCH; c++) mrd[c] = 32'h0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("abort_no_ready", 32'(ready), 32'h0);
    end
    set_cmd(0, 1'b0, 2'b00, 32'h10, 32'h0); req = 4'b0001; do_round(g);

    for (int c = 0; c < NCH; c++) set_cmd(c, 1'b0, 2'b00, 32'(4 * c), 32'h0);
    keep = 4'hF;
    do_reset(4'hF);
    for (int r = 0; r < 8; r++) begin
      do_round(g);
      check("wrap_grant", g, r % 4);
    end
    req = 4'b1000;
    do_round(g);
    check("wrap_regrant3", g, 3);
    keep = '0; req = '0;

    for (int r = 0; r < 200; r++) begin
      for (int c = 0; c < NCH; c++) begin
        if (!req[c]) begin
          req[c] = 1'($urandom_range(0, 1));
          rand_cmd(c);
        end
      end
      if (req == '0) req[$urandom_range(0, NCH - 1)] = 1'b1;
      keep = NCH'($urandom_range(0, (1 << NCH) - 1));
      do_round(g);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
